// File: rtl/conv_index_window.sv
// conv_index_window: walks the output indices of a 1-D convolution
// (FULL / SAME / VALID) and emits k together with the valid x range j_lo..j_hi.
// Optional feature macro: CONV_WIN_TAPS_EN adds taps_o = j_hi_o - j_lo_o + 1.
module conv_index_window #(
  parameter int unsigned DATAWIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [1:0]           mode_i,
  input  logic [DATAWIDTH-1:0] sizeX_i,
  input  logic [DATAWIDTH-1:0] sizeY_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic [DATAWIDTH:0]   k_o,
  output logic [DATAWIDTH-1:0] j_lo_o,
  output logic [DATAWIDTH-1:0] j_hi_o,
`ifdef CONV_WIN_TAPS_EN
  output logic [DATAWIDTH:0]   taps_o,
`endif
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int unsigned KW = DATAWIDTH + 1;

  localparam logic [1:0] MODE_FULL  = 2'b00;
  localparam logic [1:0] MODE_SAME  = 2'b01;
  localparam logic [1:0] MODE_VALID = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_RUN  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic [DATAWIDTH-1:0]   sx_q, sx_d;
  logic [DATAWIDTH-1:0]   sy_q, sy_d;
  logic [KW-1:0]          off_q, off_d;
  logic [KW-1:0]          len_q, len_d;
  logic [KW-1:0]          n_q, n_d;
  logic                   valid_q, valid_d;
  logic [KW-1:0]          k_q, k_d;
  logic [DATAWIDTH-1:0]   lo_q, lo_d;
  logic [DATAWIDTH-1:0]   hi_q, hi_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
`ifdef CONV_WIN_TAPS_EN
  logic [KW-1:0]          taps_q, taps_d;
`endif

  logic [KW-1:0]          sx_m1_c;
  logic [KW-1:0]          sy_m1_c;
  logic [KW-1:0]          off_c;
  logic [KW-1:0]          len_c;
  logic [KW-1:0]          k_sel_c;
  logic [KW-1:0]          lo_c;
  logic [KW-1:0]          hi_c;
  logic                   bad_start_c;

  // Window geometry and the tuple for the next index, all on the extended width
  always_comb begin
    sx_m1_c = KW'(sx_q) - KW'(1);
    sy_m1_c = KW'(sy_q) - KW'(1);
    off_c   = '0;
    len_c   = KW'(sx_q) + KW'(sy_q) - KW'(1);
    case (mode_q)
      MODE_SAME: begin
        off_c = sy_m1_c >> 1;
        len_c = KW'(sx_q);
      end
      MODE_VALID: begin
        off_c = sy_m1_c;
        len_c = (sy_q > sx_q) ? '0 : (KW'(sx_q) - KW'(sy_q) + KW'(1));
      end
      default: ;
    endcase
    // CALC presents index 0; RUN presents the index after the current one
    k_sel_c = (state_q == S_CALC) ? off_c : (n_q + KW'(1) + off_q);
    lo_c    = (k_sel_c >= sy_m1_c) ? (k_sel_c - sy_m1_c) : '0;
    hi_c    = (k_sel_c < sx_m1_c) ? k_sel_c : sx_m1_c;
    bad_start_c = (sizeX_i == '0) || (sizeY_i == '0) || (mode_i == MODE_RSVD);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    off_d   = off_q;
    len_d   = len_q;
    n_d     = n_q;
    valid_d = valid_q;
    k_d     = k_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef CONV_WIN_TAPS_EN
    taps_d  = taps_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d = mode_i;
          sx_d   = sizeX_i;
          sy_d   = sizeY_i;
          if (bad_start_c) begin
            err_d = 1'b1;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        off_d = off_c;
        len_d = len_c;
        n_d   = '0;
        if (len_c == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_RUN;
          valid_d = 1'b1;
          k_d     = k_sel_c;
          lo_d    = DATAWIDTH'(lo_c);
          hi_d    = DATAWIDTH'(hi_c);
`ifdef CONV_WIN_TAPS_EN
          taps_d  = hi_c - lo_c + KW'(1);
`endif
        end
      end
      S_RUN: begin
        if (ready_i) begin
          if (n_q == (len_q - KW'(1))) begin
            state_d = S_DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            n_d  = n_q + KW'(1);
            k_d  = k_sel_c;
            lo_d = DATAWIDTH'(lo_c);
            hi_d = DATAWIDTH'(hi_c);
`ifdef CONV_WIN_TAPS_EN
            taps_d = hi_c - lo_c + KW'(1);
`endif
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset wins in every state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_FULL;
      sx_q    <= '0;
      sy_q    <= '0;
      off_q   <= '0;
      len_q   <= '0;
      n_q     <= '0;
      valid_q <= 1'b0;
      k_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef CONV_WIN_TAPS_EN
      taps_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      off_q   <= off_d;
      len_q   <= len_d;
      n_q     <= n_d;
      valid_q <= valid_d;
      k_q     <= k_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef CONV_WIN_TAPS_EN
      taps_q  <= taps_d;
`endif
    end
  end

  assign valid_o = valid_q;
  assign k_o     = k_q;
  assign j_lo_o  = lo_q;
  assign j_hi_o  = hi_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign err_o   = err_q;
`ifdef CONV_WIN_TAPS_EN
  assign taps_o  = taps_q;
`endif

endmodule

// File: tb/tb_conv_index_window.sv
// Directed bench for conv_index_window: hand-computed tuple tables per mode,
// back-pressure, error starts, mid-run reset and the maximum-size sequence.
module tb_conv_index_window;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic [1:0] mode_i;
  logic [4:0] sizeX_i;
  logic [4:0] sizeY_i;
  logic       ready_i;
  logic       valid_o;
  logic [5:0] k_o;
  logic [4:0] j_lo_o;
  logic [4:0] j_hi_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;
`ifdef CONV_WIN_TAPS_EN
  logic [5:0] taps_o;
`endif

  int checks = 0;
  int errors = 0;

  int cap_k[$];
  int cap_lo[$];
  int cap_hi[$];
  int cap_tp[$];
  int first_valid;
  int done_cyc;
  int hold_viol;
  bit timed_out;

  conv_index_window #(.DATAWIDTH(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .mode_i  (mode_i),
    .sizeX_i (sizeX_i),
    .sizeY_i (sizeY_i),
    .ready_i (ready_i),
    .valid_o (valid_o),
    .k_o     (k_o),
    .j_lo_o  (j_lo_o),
    .j_hi_o  (j_hi_o),
`ifdef CONV_WIN_TAPS_EN
    .taps_o  (taps_o),
`endif
    .busy_o  (busy_o),
    .done_o  (done_o),
    .err_o   (err_o)
  );

  always #5 clk = ~clk;

  // Run one sequence, recording every transfer; cycle 0 is the start cycle.
  // rmode 0: ready always high; rmode 1: ready follows 1,0,0,1 per valid cycle.
  task automatic capture(input logic [1:0] m, input logic [4:0] sx, input logic [4:0] sy,
                         input int rmode, input bit hold_start);
    int  cyc;
    int  vcnt;
    bit  prev_stall;
    bit  r;
    int  pk, plo, phi;
    cap_k.delete(); cap_lo.delete(); cap_hi.delete(); cap_tp.delete();
    first_valid = -1; done_cyc = -1; hold_viol = 0; timed_out = 0;
    @(negedge clk);
    start_i = 1'b1; mode_i = m; sizeX_i = sx; sizeY_i = sy; ready_i = 1'b1;
    cyc = 0; vcnt = 0; prev_stall = 0; pk = 0; plo = 0; phi = 0;
    while (cyc < 300 && done_cyc < 0) begin
      @(negedge clk);
      cyc++;
      if (!hold_start) start_i = 1'b0;
      if (hold_start && cyc == 1) begin
        mode_i = 2'b01; sizeX_i = 5'd7; sizeY_i = 5'd7;
      end
      if (prev_stall && (valid_o !== 1'b1 || int'(k_o) != pk ||
                         int'(j_lo_o) != plo || int'(j_hi_o) != phi))
        hold_viol++;
      r = 1'b1;
      if (valid_o === 1'b1) begin
        if (first_valid < 0) first_valid = cyc;
        if (rmode == 1) r = ((vcnt % 4) == 0) || ((vcnt % 4) == 3);
        vcnt++;
      end
      ready_i = r;
      if (valid_o === 1'b1 && r) begin
        cap_k.push_back(int'(k_o));
        cap_lo.push_back(int'(j_lo_o));
        cap_hi.push_back(int'(j_hi_o));
`ifdef CONV_WIN_TAPS_EN
        cap_tp.push_back(int'(taps_o));
`else
        cap_tp.push_back(0);
`endif
      end
      prev_stall = (valid_o === 1'b1) && !r;
      pk = int'(k_o); plo = int'(j_lo_o); phi = int'(j_hi_o);
      if (done_o === 1'b1) begin
        done_cyc = cyc;
        start_i = 1'b0;
      end
    end
    start_i = 1'b0;
    ready_i = 1'b1;
    if (done_cyc < 0) timed_out = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; mode_i = 2'b00; sizeX_i = '0; sizeY_i = '0; ready_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_o); end
    checks++; if (k_o !== 6'd0) begin errors++; $display("FAIL reset_k got %0d exp 0", k_o); end
    checks++; if (j_lo_o !== 5'd0 || j_hi_o !== 5'd0)
      begin errors++; $display("FAIL reset_range got %0d..%0d exp 0..0", j_lo_o, j_hi_o); end
`ifdef CONV_WIN_TAPS_EN
    checks++; if (taps_o !== 6'd0) begin errors++; $display("FAIL reset_taps got %0d exp 0", taps_o); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_full();
    int ek[7]  = '{0, 1, 2, 3, 4, 5, 6};
    int elo[7] = '{0, 0, 0, 1, 2, 3, 4};
    int ehi[7] = '{0, 1, 2, 3, 4, 4, 4};
    capture(2'b00, 5'd5, 5'd3, 0, 0);
    checks++; if (timed_out) begin errors++; $display("FAIL full_timeout got no done_o exp done"); end
    checks++; if (cap_k.size() != 7) begin errors++; $display("FAIL full_count got %0d exp 7", cap_k.size()); end
    for (int i = 0; i < 7 && i < cap_k.size(); i++) begin
      checks++;
      if (cap_k[i] != ek[i] || cap_lo[i] != elo[i] || cap_hi[i] != ehi[i]) begin
        errors++;
        $display("FAIL full_tuple[%0d] got (%0d,%0d,%0d) exp (%0d,%0d,%0d)", i,
                 cap_k[i], cap_lo[i], cap_hi[i], ek[i], elo[i], ehi[i]);
      end
    end
    checks++; if (first_valid != 2) begin errors++; $display("FAIL full_first_valid got %0d exp 2", first_valid); end
    checks++; if (done_cyc != 9) begin errors++; $display("FAIL full_done_cycle got %0d exp 9", done_cyc); end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL full_idle_after got busy=%b done=%b valid=%b exp 0 0 0", busy_o, done_o, valid_o);
    end
  endtask

  task automatic test_same();
    int elo3[5] = '{0, 0, 1, 2, 3};
    int elo4[5] = '{0, 0, 0, 1, 2};
    int ehi[5]  = '{1, 2, 3, 4, 4};
    capture(2'b01, 5'd5, 5'd3, 0, 0);
    checks++; if (cap_k.size() != 5) begin errors++; $display("FAIL same3_count got %0d exp 5", cap_k.size()); end
    for (int i = 0; i < 5 && i < cap_k.size(); i++) begin
      checks++;
      if (cap_k[i] != i + 1 || cap_lo[i] != elo3[i] || cap_hi[i] != ehi[i]) begin
        errors++;
        $display("FAIL same3_tuple[%0d] got (%0d,%0d,%0d) exp (%0d,%0d,%0d)", i,
                 cap_k[i], cap_lo[i], cap_hi[i], i + 1, elo3[i], ehi[i]);
      end
    end
    capture(2'b01, 5'd5, 5'd4, 0, 0);
    checks++; if (cap_k.size() != 5) begin errors++; $display("FAIL same4_count got %0d exp 5", cap_k.size()); end
    for (int i = 0; i < 5 && i < cap_k.size(); i++) begin
      checks++;
      if (cap_k[i] != i + 1 || cap_lo[i] != elo4[i] || cap_hi[i] != ehi[i]) begin
        errors++;
        $display("FAIL same4_tuple[%0d] got (%0d,%0d,%0d) exp (%0d,%0d,%0d)", i,
                 cap_k[i], cap_lo[i], cap_hi[i], i + 1, elo4[i], ehi[i]);
      end
    end
  endtask

  task automatic test_valid();
    capture(2'b10, 5'd5, 5'd3, 0, 0);
    checks++; if (cap_k.size() != 3) begin errors++; $display("FAIL valid_count got %0d exp 3", cap_k.size()); end
    for (int i = 0; i < 3 && i < cap_k.size(); i++) begin
      checks++;
      if (cap_k[i] != i + 2 || cap_lo[i] != i || cap_hi[i] != i + 2) begin
        errors++;
        $display("FAIL valid_tuple[%0d] got (%0d,%0d,%0d) exp (%0d,%0d,%0d)", i,
                 cap_k[i], cap_lo[i], cap_hi[i], i + 2, i, i + 2);
      end
    end
    capture(2'b10, 5'd2, 5'd4, 0, 0);
    checks++; if (first_valid != -1) begin errors++; $display("FAIL valid_empty_valid got cycle %0d exp none", first_valid); end
    checks++; if (done_cyc != 2) begin errors++; $display("FAIL valid_empty_done got %0d exp 2", done_cyc); end
  endtask

  task automatic test_backpressure();
    int elo[7] = '{0, 0, 0, 1, 2, 3, 4};
    int ehi[7] = '{0, 1, 2, 3, 4, 4, 4};
    capture(2'b00, 5'd5, 5'd3, 1, 0);
    checks++; if (cap_k.size() != 7) begin errors++; $display("FAIL bp_count got %0d exp 7", cap_k.size()); end
    for (int i = 0; i < 7 && i < cap_k.size(); i++) begin
      checks++;
      if (cap_k[i] != i || cap_lo[i] != elo[i] || cap_hi[i] != ehi[i]) begin
        errors++;
        $display("FAIL bp_tuple[%0d] got (%0d,%0d,%0d) exp (%0d,%0d,%0d)", i,
                 cap_k[i], cap_lo[i], cap_hi[i], i, elo[i], ehi[i]);
      end
    end
    checks++; if (hold_viol != 0) begin errors++; $display("FAIL bp_hold got %0d changes exp 0", hold_viol); end
    checks++; if (done_cyc != 15) begin errors++; $display("FAIL bp_done_cycle got %0d exp 15", done_cyc); end
  endtask

  task automatic test_start_in_run();
    int elo[7] = '{0, 0, 0, 1, 2, 3, 4};
    int ehi[7] = '{0, 1, 2, 3, 4, 4, 4};
    capture(2'b00, 5'd5, 5'd3, 0, 1);
    checks++; if (cap_k.size() != 7) begin errors++; $display("FAIL sir_count got %0d exp 7", cap_k.size()); end
    for (int i = 0; i < 7 && i < cap_k.size(); i++) begin
      checks++;
      if (cap_k[i] != i || cap_lo[i] != elo[i] || cap_hi[i] != ehi[i]) begin
        errors++;
        $display("FAIL sir_tuple[%0d] got (%0d,%0d,%0d) exp (%0d,%0d,%0d)", i,
                 cap_k[i], cap_lo[i], cap_hi[i], i, elo[i], ehi[i]);
      end
    end
    checks++; if (done_cyc != 9) begin errors++; $display("FAIL sir_done_cycle got %0d exp 9", done_cyc); end
  endtask

  task automatic test_errors();
    logic [1:0] em[2]  = '{2'b00, 2'b11};
    logic [4:0] ey[2]  = '{5'd0, 5'd3};
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      start_i = 1'b1; mode_i = em[t]; sizeX_i = 5'd5; sizeY_i = ey[t];
      @(negedge clk);
      start_i = 1'b0;
      checks++;
      if (err_o !== 1'b1 || busy_o !== 1'b0 || valid_o !== 1'b0) begin
        errors++;
        $display("FAIL err_pulse[%0d] got err=%b busy=%b valid=%b exp 1 0 0", t, err_o, busy_o, valid_o);
      end
      @(negedge clk);
      checks++;
      if (err_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL err_clear[%0d] got err=%b busy=%b exp 0 0", t, err_o, busy_o);
      end
    end
  endtask

  task automatic test_abort();
    int n;
    @(negedge clk);
    start_i = 1'b1; mode_i = 2'b00; sizeX_i = 5'd5; sizeY_i = 5'd3; ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n = 0;
    while (!(valid_o === 1'b1 && k_o === 6'd2) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n >= 20) begin errors++; $display("FAIL abort_third got no k=2 tuple exp one"); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0 ||
        k_o !== 6'd0 || j_lo_o !== 5'd0 || j_hi_o !== 5'd0) begin
      errors++;
      $display("FAIL abort_outputs got v=%b b=%b d=%b e=%b k=%0d lo=%0d hi=%0d exp all 0",
               valid_o, busy_o, done_o, err_o, k_o, j_lo_o, j_hi_o);
    end
    capture(2'b00, 5'd5, 5'd3, 0, 0);
    checks++; if (cap_k.size() != 7) begin errors++; $display("FAIL abort_rerun_count got %0d exp 7", cap_k.size()); end
    checks++;
    if (cap_k.size() != 7 || cap_k[6] != 6 || cap_lo[6] != 4 || cap_hi[6] != 4 || first_valid != 2) begin
      errors++;
      $display("FAIL abort_rerun_last got size=%0d first_valid=%0d exp last (6,4,4) at first_valid 2",
               cap_k.size(), first_valid);
    end
  endtask

  task automatic test_boundary();
    capture(2'b00, 5'd31, 5'd31, 0, 0);
    checks++; if (cap_k.size() != 61) begin errors++; $display("FAIL bnd_count got %0d exp 61", cap_k.size()); end
    if (cap_k.size() == 61) begin
      checks++;
      if (cap_k[60] != 60 || cap_lo[60] != 30 || cap_hi[60] != 30) begin
        errors++;
        $display("FAIL bnd_last got (%0d,%0d,%0d) exp (60,30,30)", cap_k[60], cap_lo[60], cap_hi[60]);
      end
      checks++;
      if (cap_k[30] != 30 || cap_lo[30] != 0 || cap_hi[30] != 30) begin
        errors++;
        $display("FAIL bnd_mid got (%0d,%0d,%0d) exp (30,0,30)", cap_k[30], cap_lo[30], cap_hi[30]);
      end
      checks++;
      if (cap_k[45] != 45 || cap_lo[45] != 15 || cap_hi[45] != 30) begin
        errors++;
        $display("FAIL bnd_k45 got (%0d,%0d,%0d) exp (45,15,30)", cap_k[45], cap_lo[45], cap_hi[45]);
      end
`ifdef CONV_WIN_TAPS_EN
      checks++;
      if (cap_tp[30] != 31 || cap_tp[0] != 1 || cap_tp[60] != 1) begin
        errors++;
        $display("FAIL bnd_taps got %0d/%0d/%0d exp 1/31/1", cap_tp[0], cap_tp[30], cap_tp[60]);
      end
`endif
    end
    checks++; if (done_cyc != 63) begin errors++; $display("FAIL bnd_done_cycle got %0d exp 63", done_cyc); end
  endtask

  initial begin
    test_reset();
    test_full();
    test_same();
    test_valid();
    test_backpressure();
    test_start_in_run();
    test_errors();
    test_abort();
    test_boundary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
